// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs 2*BITS_DATA-wide add/sub/and/or/not as chained passes
// through an external BITS_DATA-wide combinational ALU, with valid/ready request and response ports.
`ifndef OP_ADD
`define OP_ADD 5'b00000
`endif
`ifndef OP_SUB
`define OP_SUB 5'b00001
`endif
`ifndef OP_AND
`define OP_AND 5'b00010
`endif
`ifndef OP_OR
`define OP_OR 5'b00011
`endif
`ifndef OP_NOT
`define OP_NOT 5'b00100
`endif

module alu_wide_sequencer #(
    parameter int BITS_DATA = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [2*BITS_DATA-1:0] req_a,
    input  logic [2*BITS_DATA-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*BITS_DATA-1:0] rsp_result,
    output logic                   rsp_C,
    output logic                   rsp_S,
    output logic                   rsp_O,
    output logic                   rsp_Z,
    output logic                   rsp_err,
    output logic [4:0]             alu_opcode,
    output logic [BITS_DATA-1:0]   alu_operando_a,
    output logic [BITS_DATA-1:0]   alu_operando_b,
    input  logic [BITS_DATA-1:0]   alu_resultado,
    input  logic                   alu_C,
    input  logic                   alu_S,
    input  logic                   alu_O,
    input  logic                   alu_Z
);
    localparam int W2 = 2 * BITS_DATA;

    typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} state_t;

    state_t               state, state_nxt;
    logic [2:0]           op_q;
    logic [W2-1:0]        a_q, b_q;
    logic [BITS_DATA-1:0] r_lo, t;
    logic                 c0, c1;
    logic [4:0]           op_alu;
    logic                 arith, is_sub, is_not, accept;
    logic [W2-1:0]        fin;
    logic                 fin_c, fin_o;
    logic                 unused_flags;

    assign unused_flags = alu_S ^ alu_O ^ alu_Z;
    assign req_ready    = state == IDLE && !reset;
    assign rsp_valid    = state == DONE;
    assign accept       = req_valid && req_ready;
    assign arith        = op_q == 3'd0 || op_q == 3'd1;
    assign is_sub       = op_q == 3'd1;
    assign is_not       = op_q == 3'd4;
    assign op_alu       = op_q == 3'd0 ? `OP_ADD :
                          op_q == 3'd1 ? `OP_SUB :
                          op_q == 3'd2 ? `OP_AND :
                          op_q == 3'd3 ? `OP_OR  : `OP_NOT;

    // Final result/flags as they stand on the edge that enters DONE from HI or FIX
    assign fin   = {alu_resultado, r_lo};
    assign fin_c = arith && (alu_C || (state == FIX && c1));
    assign fin_o = arith && (is_sub ? a_q[W2-1] != b_q[W2-1] : a_q[W2-1] == b_q[W2-1])
                         && fin[W2-1] != a_q[W2-1];

    always_comb begin
        state_nxt      = state;
        alu_opcode     = `OP_AND;
        alu_operando_a = '0;
        alu_operando_b = '0;
        case (state)
            IDLE: if (accept) state_nxt = req_op <= 3'd4 ? LO : DONE;
            LO: begin
                alu_opcode     = op_alu;
                alu_operando_a = a_q[BITS_DATA-1:0];
                alu_operando_b = is_not ? '0 : b_q[BITS_DATA-1:0];
                state_nxt      = HI;
            end
            HI: begin
                alu_opcode     = op_alu;
                alu_operando_a = a_q[W2-1:BITS_DATA];
                alu_operando_b = is_not ? '0 : b_q[W2-1:BITS_DATA];
                state_nxt      = arith && c0 ? FIX : DONE;
            end
            FIX: begin
                alu_opcode     = op_alu;
                alu_operando_a = t;
                alu_operando_b = BITS_DATA'(1);
                state_nxt      = DONE;
            end
            DONE: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            r_lo       <= '0;
            t          <= '0;
            c0         <= 1'b0;
            c1         <= 1'b0;
            rsp_result <= '0;
            rsp_C      <= 1'b0;
            rsp_S      <= 1'b0;
            rsp_O      <= 1'b0;
            rsp_Z      <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
            end
            if (state == LO) begin
                r_lo <= alu_resultado;
                c0   <= alu_C;
            end
            if (state == HI) begin
                t  <= alu_resultado;
                c1 <= alu_C;
            end
            // An illegal op reaches DONE straight from IDLE with a zeroed response
            if (state != DONE && state_nxt == DONE) begin
                rsp_err    <= state == IDLE;
                rsp_result <= state == IDLE ? '0 : fin;
                rsp_C      <= state != IDLE && fin_c;
                rsp_S      <= state != IDLE && fin[W2-1];
                rsp_O      <= state != IDLE && fin_o;
                rsp_Z      <= state != IDLE && fin == '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb_alu_wide_sequencer: randomized and directed scoreboard bench with a behavioural
// 32-bit ALU and a 64-bit reference model of results, flags and response latency.
`ifndef OP_ADD
`define OP_ADD 5'b00000
`endif
`ifndef OP_SUB
`define OP_SUB 5'b00001
`endif
`ifndef OP_AND
`define OP_AND 5'b00010
`endif
`ifndef OP_OR
`define OP_OR 5'b00011
`endif
`ifndef OP_NOT
`define OP_NOT 5'b00100
`endif

module tb_alu_wide_sequencer;
    localparam int W = 32;

    logic clk = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, req_ready;
    logic [2:0] req_op = '0;
    logic [2*W-1:0] req_a = '0, req_b = '0;
    logic rsp_valid, rsp_ready;
    logic [2*W-1:0] rsp_result;
    logic rsp_C, rsp_S, rsp_O, rsp_Z, rsp_err;
    logic [4:0] alu_opcode;
    logic [W-1:0] alu_operando_a, alu_operando_b, alu_resultado;
    logic alu_C, alu_S, alu_O, alu_Z;

    alu_wide_sequencer #(.BITS_DATA(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_C(rsp_C), .rsp_S(rsp_S), .rsp_O(rsp_O), .rsp_Z(rsp_Z), .rsp_err(rsp_err),
        .alu_opcode(alu_opcode), .alu_operando_a(alu_operando_a),
        .alu_operando_b(alu_operando_b), .alu_resultado(alu_resultado),
        .alu_C(alu_C), .alu_S(alu_S), .alu_O(alu_O), .alu_Z(alu_Z)
    );

    always #5 clk = ~clk;

    // Behavioural 32-bit ALU; SUB carry reports an unsigned borrow
    always_comb begin
        alu_resultado = '0;
        alu_C = 1'b0;
        case (alu_opcode)
            `OP_ADD: {alu_C, alu_resultado} = {1'b0, alu_operando_a} + {1'b0, alu_operando_b};
            `OP_SUB: begin
                alu_resultado = alu_operando_a - alu_operando_b;
                alu_C = alu_operando_a < alu_operando_b;
            end
            `OP_AND: alu_resultado = alu_operando_a & alu_operando_b;
            `OP_OR:  alu_resultado = alu_operando_a | alu_operando_b;
            `OP_NOT: alu_resultado = ~alu_operando_a;
            default: ;
        endcase
        alu_S = alu_resultado[W-1];
        alu_O = 1'b0;
        alu_Z = alu_resultado == '0;
    end

    typedef struct {
        logic [63:0] r;
        logic c, s, o, z, err;
        int e;
        int lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0, passes = 0, cyc = 0;
    logic hold = 1'b0, pv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [2:0] op, input logic [63:0] a, b, input int e);
        exp_t x;
        logic [64:0] s;
        logic [32:0] lo;
        x = '{r: '0, c: 0, s: 0, o: 0, z: 0, err: 0, e: e, lat: 2};
        lo = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                x.r = s[63:0];
                x.c = s[64];
                x.o = a[63] == b[63] && x.r[63] != a[63];
                x.lat = lo[32] ? 3 : 2;
            end
            3'd1: begin
                x.r = a - b;
                x.c = a < b;
                x.o = a[63] != b[63] && x.r[63] != a[63];
                x.lat = a[31:0] < b[31:0] ? 3 : 2;
            end
            3'd2: x.r = a & b;
            3'd3: x.r = a | b;
            3'd4: x.r = ~a;
            default: begin
                x.err = 1'b1;
                x.lat = 0;
            end
        endcase
        if (!x.err) begin
            x.s = x.r[63];
            x.z = x.r == '0;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2 rsp_ready = hold ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    // Monitor: latency on the rising edge of rsp_valid, contents on the handshake
    always @(negedge clk) begin
        if (reset) pv = 1'b0;
        else begin
            if (rsp_valid && !pv) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_rsp: result %h with empty scoreboard", rsp_result);
                end else chk("latency", 64'(cyc - sb[0].e), 64'(sb[0].lat));
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                chk("result", rsp_result, sb[0].r);
                chk("flags_CSOZE", {59'd0, rsp_C, rsp_S, rsp_O, rsp_Z, rsp_err},
                    {59'd0, sb[0].c, sb[0].s, sb[0].o, sb[0].z, sb[0].err});
                void'(sb.pop_front());
            end
            pv = rsp_valid;
        end
    end

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        @(negedge clk);
        req_op = op;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            $display("FAIL accept_timeout: req_ready 0, required 1 within 300 cycles");
            req_valid = 1'b0;
            return;
        end
        sb.push_back(model(op, a, b, cyc + 1));
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] a, b;
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 0);
        chk("reset_req_ready", 64'(req_ready), 0);
        chk("reset_result", rsp_result, 0);
        chk("reset_flags", {59'd0, rsp_C, rsp_S, rsp_O, rsp_Z, rsp_err}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 chk("ready_after_reset", 64'(req_ready), 1);

        send(3'd0, 64'h00000000_FFFFFFFF, 64'd1);
        send(3'd0, 64'hFFFFFFFF_FFFFFFFF, 64'd1);
        send(3'd0, 64'h7FFFFFFF_FFFFFFFF, 64'd1);
        send(3'd1, 64'h00000001_00000000, 64'd1);
        send(3'd1, 64'd0, 64'd1);
        send(3'd1, 64'h80000000_00000000, 64'd1);
        send(3'd4, 64'd0, 64'hDEADBEEF_12345678);
        send(3'd2, 64'hF0F0F0F0_F0F0F0F0, 64'h0F0F0F0F_0F0F0F0F);
        send(3'd3, 64'h12340000_00005678, 64'h00009ABC_DEF00000);
        drain();

        // Illegal op held under backpressure while req_valid toggles
        hold = 1'b1;
        send(3'b101, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_req_ready", 64'(req_ready), 0);
            chk("hold_rsp_valid", 64'(rsp_valid), 1);
            chk("hold_result", rsp_result, 0);
            chk("hold_err", 64'(rsp_err), 1);
            req_op = 3'd0;
            req_valid = i[0];
        end
        req_valid = 1'b0;
        hold = 1'b0;
        drain();

        // Reset while the high pass is on the ALU
        send(3'd0, 64'h00000000_FFFFFFFF, 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_rsp_valid", 64'(rsp_valid), 0);
        chk("abort_req_ready", 64'(req_ready), 0);
        chk("abort_result", rsp_result, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 chk("abort_ready_after", 64'(req_ready), 1);
        send(3'd0, 64'h00000005_FFFFFFF0, 64'h00000002_00000020);
        drain();

        for (int i = 0; i < 60; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(3) == 0) a[31:0] = '1;
            if ($urandom_range(3) == 0) b[63:32] = a[63:32];
            send(3'($urandom_range(7)), a, b);
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/alu_wide_sequencer.md
# alu_wide_sequencer

Multi-cycle 2×BITS_DATA (64-bit default) arithmetic/logic engine that acts as the initiator for the combinational ALU. Requests arrive on a valid/ready port. The block splits each request into BITS_DATA-wide passes and drives them through an external ALU instance, one pass per cycle. It chains carry/borrow between passes and returns a 64-bit result plus C/S/O/Z on a valid/ready response port. It sits between the datapath controller and the ALU.

## Interface
- BITS_DATA, 32, width of the ALU datapath; request/response words are 2*BITS_DATA.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only when state==IDLE and reset low (combinational).
- req_op  in  3  operation code: 000 ADD64, 001 SUB64, 010 AND64, 011 OR64, 100 NOT64; 101–111 are illegal.
- req_a, req_b  in  2*BITS_DATA  operands; req_b is ignored for NOT64.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_result  out  2*BITS_DATA  result.
- rsp_C, rsp_S, rsp_O, rsp_Z  out  1 each  flags of the full-width result.
- rsp_err  out  1  illegal req_op.
- alu_opcode  out  5  driven with `OP_* macros from opcodes.vh.
- alu_operando_a, alu_operando_b  out  BITS_DATA  ALU operands.
- alu_resultado  in  BITS_DATA  ALU result.
- alu_C, alu_S, alu_O, alu_Z  in  1 each  ALU flags; only alu_C is used.

## Operation
- States: IDLE, LO, HI, FIX, DONE.
- **IDLE**
  - On req_valid && req_ready, capture op, a and b.
  - Legal op: go to LO. Illegal op: go to DONE with rsp_err=1, result 0, all flags 0.
- **LO**: drive the low halves (`OP_ADD / `OP_SUB / `OP_AND / `OP_OR / `OP_NOT). At the edge, r_lo ← alu_resultado and c0 ← alu_C. Go to HI.
- **HI**: drive the high halves with the same opcode. At the edge, capture t ← alu_resultado and c1 ← alu_C.
  - ADD64/SUB64 with c0=1: go to FIX.
  - Otherwise: r_hi ← t and go to DONE.
- **FIX**: drive alu_operando_a=t and alu_operando_b=1 with the op's opcode (ADD adds carry, SUB subtracts borrow). At the edge, r_hi ← alu_resultado and c2 ← alu_C. Go to DONE.
- **Flags**, computed locally from the full 64-bit values (ALU S/O/Z are not used):
  - S = r[2W-1].
  - Z = (r==0).
  - ADD64: C = c1|c2; O = (a_msb==b_msb) && (r_msb!=a_msb).
  - SUB64: C = c1|c2, where C=1 means unsigned borrow (a<b); O = (a_msb!=b_msb) && (r_msb!=a_msb).
  - AND/OR/NOT: C=0, O=0.
- **DONE**
  - rsp_valid=1. rsp_* are held stable until rsp_ready.
  - rsp_valid && rsp_ready moves the FSM to IDLE and clears rsp_valid.
- **ALU drive outside LO/HI/FIX**: alu_opcode=`OP_AND, both alu operands 0. NOT passes drive alu_operando_b=0.
- **Arithmetic**: all operations are modulo 2^(2W). c1 and c2 are never both 1.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_result 0, all rsp flags 0, rsp_err 0, internal regs 0. req_ready is 0 while reset is high.
- Let E be the accept edge. rsp_valid is high after:
  - edge E+2 for two-pass ops (AND/OR/NOT, and ADD/SUB with c0=0);
  - edge E+3 when FIX is taken;
  - edge E for illegal ops.
- No pipelining: one request in flight. req_ready is low from E until the cycle after the response handshake; the earliest next accept is the edge after the rsp handshake edge.
- Backpressure: rsp_ready low holds DONE indefinitely with outputs unchanged; req_valid is ignored during this time.
- Reset asserted in any state: the operation is aborted immediately and every output returns to its reset value. There is no partial response.

## Test plan
- ADD64 a=0x00000000_FFFFFFFF, b=1 -> result 0x00000001_00000000, C=0, O=0, S=0, Z=0; FIX taken, rsp_valid after E+3.
  - a=0xFFFFFFFF_FFFFFFFF, b=1 -> result 0, C=1, Z=1, O=0.
- ADD64 a=0x7FFFFFFF_FFFFFFFF, b=1 -> 0x80000000_00000000, O=1, S=1, C=0.
- SUB64 a=0x00000001_00000000, b=1 -> 0x00000000_FFFFFFFF, C=0, FIX taken.
  - a=0, b=1 -> 0xFFFFFFFF_FFFFFFFF, C=1, S=1, O=0.
  - a=0x80000000_00000000, b=1 -> O=1.
- NOT64 a=0 -> all ones, S=1, C=0, O=0, rsp_valid after E+2.
  - AND64 0xF0F0F0F0_F0F0F0F0 & 0x0F0F0F0F_0F0F0F0F -> 0, Z=1.
- Illegal op 3'b101 -> rsp_valid after E, rsp_err=1, result 0.
  - Then hold rsp_ready low 5 cycles while pulsing req_valid: outputs stable, req_ready=0, no new accept.
- Assert reset while in HI -> rsp_valid=0 and req_ready=0 immediately; after deassert, req_ready=1 and a fresh ADD64 completes correctly.
